// File: rtl/reg_swap_seq_pkg.sv
// rtl/reg_swap_seq_pkg.sv - shared state encoding and default sizes for the register swap engine
//
// Purpose : state_t encoding used by the exchange FSM, plus the default
//           register width and address width for the interface and top.
// Ports   : none (package)
// Options : SWAP_NIBBLE_EN adds the S_WR_N state used by the nibble-swap path.
package reg_swap_seq_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4,
        S_DONE = 3'd5
`ifdef SWAP_NIBBLE_EN
        ,
        S_WR_N = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/reg_swap_seq_if.sv
// rtl/reg_swap_seq_if.sv - control-unit and register-file signals of the register swap engine
//
// Purpose : bundles the request handshake (req/addr_a/addr_b/busy/done) and
//           the single read port / single write port towards the register file.
// Modports: master - control unit + register file side (drives req, addresses, rf_rdata)
//           slave  - the swap engine (drives busy, done and the rf read/write port)
// Options : SWAP_NIBBLE_EN adds the nib request qualifier.
interface reg_swap_seq_if
    import reg_swap_seq_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
);

    logic          req;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
`ifdef SWAP_NIBBLE_EN
    logic          nib;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    modport master (
        output req, addr_a, addr_b,
`ifdef SWAP_NIBBLE_EN
        output nib,
`endif
        output rf_rdata,
        input  busy, done, rf_raddr, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  req, addr_a, addr_b,
`ifdef SWAP_NIBBLE_EN
        input  nib,
`endif
        input  rf_rdata,
        output busy, done, rf_raddr, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/reg_swap_seq.sv
// rtl/reg_swap_seq.sv - sequential two-register exchange engine using one rf read and one rf write port
//
// Purpose : on an accepted req, reads register ra then rb into tmp_a/tmp_b,
//           writes tmp_b to ra and tmp_a to rb, then pulses done. Both reads
//           finish before the first write, so a bypassing register file is safe.
//           Equal addresses skip straight to DONE with no writes.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - reg_swap_seq_if.slave (req/addr_a/addr_b in, busy/done out,
//                   rf_raddr/rf_rdata read port, rf_we/rf_waddr/rf_wdata write port)
// Options : SWAP_NIBBLE_EN - req with nib=1 swaps the two nibbles of addr_a
//           (IDLE -> RD_A -> WR_N -> DONE).
module reg_swap_seq
    import reg_swap_seq_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_swap_seq_if.slave bus
);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] tmp_a;
    logic [DW-1:0] tmp_b;
`ifdef SWAP_NIBBLE_EN
    logic          nib_q;
`endif

    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] raddr_o;
    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address and data latches; addresses are only captured on accept, so
    // later changes on addr_a/addr_b (or a req while busy) have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            tmp_a <= '0;
            tmp_b <= '0;
`ifdef SWAP_NIBBLE_EN
            nib_q <= 1'b0;
`endif
        end else begin
            if (state_q == S_IDLE && bus.req) begin
                ra <= bus.addr_a;
                rb <= bus.addr_b;
`ifdef SWAP_NIBBLE_EN
                nib_q <= bus.nib;
`endif
            end
            if (state_q == S_RD_A) begin
                tmp_a <= bus.rf_rdata;
            end
            if (state_q == S_RD_B) begin
                tmp_b <= bus.rf_rdata;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (bus.addr_a == bus.addr_b) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_A;
                    end
`ifdef SWAP_NIBBLE_EN
                    // Nibble swap ignores addr_b, so equality must not short-cut it.
                    if (bus.nib) begin
                        state_d = S_RD_A;
                    end
`endif
                end
            end
`ifdef SWAP_NIBBLE_EN
            S_RD_A:  state_d = nib_q ? S_WR_N : S_RD_B;
            S_WR_N:  state_d = S_DONE;
`else
            S_RD_A:  state_d = S_RD_B;
`endif
            S_RD_B:  state_d = S_WR_A;
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        busy_o  = (state_q != S_IDLE);
        done_o  = (state_q == S_DONE);
        raddr_o = (state_q == S_RD_B) ? rb : ra;
        we_o    = 1'b0;
        waddr_o = ra;
        wdata_o = '0;
        case (state_q)
            S_WR_A: begin
                we_o    = 1'b1;
                wdata_o = tmp_b;
            end
            S_WR_B: begin
                we_o    = 1'b1;
                waddr_o = rb;
                wdata_o = tmp_a;
            end
`ifdef SWAP_NIBBLE_EN
            S_WR_N: begin
                we_o    = 1'b1;
                wdata_o = {tmp_a[DW/2-1:0], tmp_a[DW-1:DW/2]};
            end
`endif
            default: begin
                we_o = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy_o;
    assign bus.done     = done_o;
    assign bus.rf_raddr = raddr_o;
    assign bus.rf_we    = we_o;
    assign bus.rf_waddr = waddr_o;
    assign bus.rf_wdata = wdata_o;

endmodule

// File: tb/tb_reg_swap_seq.sv
// tb/tb_reg_swap_seq.sv - self-checking bench for reg_swap_seq with a behavioural register-file model
module tb_reg_swap_seq;

    logic clk;
    logic rst_n;

    reg_swap_seq_if #(.DW(8), .AW(3)) bus ();

    reg_swap_seq #(.DW(8), .AW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file seen by the DUT, plus a preload port for the bench.
    logic [7:0] rf [8];
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;

    assign bus.rf_rdata = rf[bus.rf_raddr];

    always @(posedge clk) begin
        if (bus.rf_we) begin
            rf[bus.rf_waddr] <= bus.rf_wdata;
        end else if (ld_en) begin
            rf[ld_addr] <= ld_data;
        end
    end

    // Every write the DUT issues, in order.
    int wr_q[$];
    always @(negedge clk) begin
        if (bus.rf_we) wr_q.push_back(int'(bus.rf_waddr));
    end

    // Reference model: register contents and expected write sequence.
    logic [7:0] ref_rf [8];
    int         exp_w[$];

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_reg(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        ref_rf[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) chk($sformatf("%s rf[%0d]", tag, i), rf[i], ref_rf[i]);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, " nwr"}, wr_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
            chk($sformatf("%s waddr%0d", tag, i), wr_q[i], exp_w[i]);
    endtask

    // Issues one request from IDLE and returns the cycle (1 = cycle after accept)
    // in which done was seen, plus the number of those cycles with busy high.
    task automatic do_swap(input logic [2:0] a, input logic [2:0] b, input logic nb,
                           input bit glitch, output int lat, output int busy_n);
        wr_q.delete();
        @(posedge clk); #1;
        chk("idle done", bus.done, 1'b0);
        chk("idle busy", bus.busy, 1'b0);
        bus.req = 1'b1; bus.addr_a = a; bus.addr_b = b;
`ifdef SWAP_NIBBLE_EN
        bus.nib = nb;
`endif
        @(posedge clk); #1;
        bus.req = 1'b0;
        bus.addr_a = 3'($urandom); bus.addr_b = 3'($urandom);
`ifdef SWAP_NIBBLE_EN
        bus.nib = 1'($urandom);
`endif
        lat = 0; busy_n = 0;
        for (int k = 1; k <= 12; k++) begin
            if (bus.busy) busy_n++;
            if (glitch && k == 2) begin
                bus.req = 1'b1; bus.addr_a = 3'd0; bus.addr_b = 3'd1;
            end else if (glitch && k == 3) begin
                bus.req = 1'b0;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        if (nb == 1'b0) begin end
    endtask

    // Reference rules for one request: updates ref_rf, exp_w and the latency.
    task automatic model_swap(input logic [2:0] a, input logic [2:0] b, input logic nb, output int lat);
        logic [7:0] t;
        exp_w.delete();
        if (nb) begin
            t = ref_rf[a];
            ref_rf[a] = {t[3:0], t[7:4]};
            exp_w.push_back(a);
            lat = 3;
        end else if (a == b) begin
            lat = 1;
        end else begin
            t = ref_rf[a];
            ref_rf[a] = ref_rf[b];
            ref_rf[b] = t;
            exp_w.push_back(a);
            exp_w.push_back(b);
            lat = 5;
        end
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.done) begin
                n = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bn, exp_lat, n1, n2;
        logic [2:0] a, b;
        logic nb;
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; bus.req = 1'b0; bus.addr_a = '0; bus.addr_b = '0;
`ifdef SWAP_NIBBLE_EN
        bus.nib = 1'b0;
`endif
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst we", bus.rf_we, 1'b0);
        chk("rst raddr", bus.rf_raddr, 3'd0);
        chk("rst waddr", bus.rf_waddr, 3'd0);
        chk("rst wdata", bus.rf_wdata, 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) set_reg(3'(i), 8'($urandom));

        // Basic exchange R2/R5
        set_reg(3'd2, 8'h3C); set_reg(3'd5, 8'hA1);
        model_swap(3'd2, 3'd5, 1'b0, exp_lat);
        do_swap(3'd2, 3'd5, 1'b0, 1'b0, lat, bn);
        chk("swap25 lat", lat, 5);
        chk("swap25 busy", bn, 5);
        check_writes("swap25");
        chk("swap25 R2", rf[2], 8'hA1);
        chk("swap25 R5", rf[5], 8'h3C);
        check_regs("swap25");

        // Equal addresses
        set_reg(3'd4, 8'h77);
        model_swap(3'd4, 3'd4, 1'b0, exp_lat);
        do_swap(3'd4, 3'd4, 1'b0, 1'b0, lat, bn);
        chk("eq lat", lat, 1);
        check_writes("eq");
        chk("eq R4", rf[4], 8'h77);

        // req while busy is ignored
        model_swap(3'd3, 3'd6, 1'b0, exp_lat);
        do_swap(3'd3, 3'd6, 1'b0, 1'b1, lat, bn);
        chk("glitch lat", lat, exp_lat);
        chk("glitch busy", bn, exp_lat);
        check_writes("glitch");
        @(posedge clk); #1;
        chk("glitch idle busy", bus.busy, 1'b0);
        check_regs("glitch");

        // Reset during WR_B
        set_reg(3'd1, 8'h11); set_reg(3'd6, 8'h66);
        wr_q.delete();
        @(posedge clk); #1;
        bus.req = 1'b1; bus.addr_a = 3'd1; bus.addr_b = 3'd6;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("wrb we", bus.rf_we, 1'b1);
        chk("wrb waddr", bus.rf_waddr, 3'd6);
        rst_n = 1'b0;
        #1;
        chk("midrst we", bus.rf_we, 1'b0);
        chk("midrst busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst busy", bus.busy, 1'b0);
        chk("postrst done", bus.done, 1'b0);
        chk("postrst R1", rf[1], 8'h66);
        chk("postrst R6", rf[6], 8'h66);
        chk("postrst nwr", wr_q.size(), 1);
        ref_rf[1] = 8'h66;
        check_regs("postrst");

        // Back-to-back with req held high
        wr_q.delete();
        @(posedge clk); #1;
        bus.req = 1'b1; bus.addr_a = 3'd0; bus.addr_b = 3'd7;
        wait_done(n1);
        chk("b2b first", n1, 5);
        bus.addr_a = 3'd7; bus.addr_b = 3'd0;
        @(posedge clk); #1;
        wait_done(n2);
        chk("b2b second", n2, 5);
        bus.req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b idle", bus.busy, 1'b0);
        exp_w.delete();
        exp_w.push_back(0); exp_w.push_back(7); exp_w.push_back(7); exp_w.push_back(0);
        check_writes("b2b");
        check_regs("b2b");

`ifdef SWAP_NIBBLE_EN
        // Nibble swap
        set_reg(3'd3, 8'h5E);
        model_swap(3'd3, 3'd1, 1'b1, exp_lat);
        do_swap(3'd3, 3'd1, 1'b1, 1'b0, lat, bn);
        chk("nib lat", lat, 3);
        check_writes("nib");
        chk("nib R3", rf[3], 8'hE5);
`endif

        // Randomized requests against the model
        for (int it = 0; it < 24; it++) begin
            a = 3'($urandom_range(0, 7));
            b = ($urandom_range(0, 3) == 0) ? a : 3'($urandom_range(0, 7));
            nb = 1'b0;
`ifdef SWAP_NIBBLE_EN
            nb = ($urandom_range(0, 2) == 0);
`endif
            model_swap(a, b, nb, exp_lat);
            do_swap(a, b, nb, 1'b0, lat, bn);
            chk($sformatf("rnd%0d lat", it), lat, exp_lat);
            chk($sformatf("rnd%0d busy", it), bn, exp_lat);
            check_writes($sformatf("rnd%0d", it));
        end
        @(posedge clk); #1;
        check_regs("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
